// File: rtl/vx_barrier_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vx_barrier_unit                                              |
// | Description : Warp barrier collector. Each of NUM_BARRIERS slots gathers   |
// |               arriving warps into a mask until the number of arrivals      |
// |               reaches req_size_m1+1. The slot then spends one cycle in     |
// |               RELEASE, pulsing release_valid/release_wmask, and returns to |
// |               IDLE.                                                        |
// | Ports       : clk, reset_n (async, active-low)                             |
// |               req_valid/req_wid/req_id/req_size_m1 -> req_ready            |
// |               stall_mask    : warps held at any barrier                    |
// |               release_valid : one-cycle release pulse                      |
// |               release_wmask : warps released this cycle                    |
// |               err_dup       : one-cycle pulse after a duplicate arrival    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vx_barrier_unit #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  localparam int NW_BITS     = $clog2(NUM_WARPS),
  localparam int NB_BITS     = $clog2(NUM_BARRIERS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  input  logic [NW_BITS-1:0]   req_wid,
  input  logic [NB_BITS-1:0]   req_id,
  input  logic [NW_BITS-1:0]   req_size_m1,
  output logic                 req_ready,
  output logic [NUM_WARPS-1:0] stall_mask,
  output logic                 release_valid,
  output logic [NUM_WARPS-1:0] release_wmask,
  output logic                 err_dup
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_COLLECT = 2'd1;
  localparam logic [1:0] c_RELEASE = 2'd2;

  logic [1:0]           w_state [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] w_mask  [NUM_BARRIERS];

  logic [NUM_WARPS-1:0] w_onehot;
  logic [NUM_WARPS-1:0] w_stall;
  logic [NUM_WARPS-1:0] w_rel_mask;
  logic                 w_rel_valid;
  logic                 w_ready;
  logic                 w_dup;
  logic                 w_accept;
  logic                 w_arrive;
  logic                 r_err_dup;

  assign w_onehot = NUM_WARPS'(1) << req_wid;

  // Idle slots always hold a cleared mask, so the OR over non-idle slots is
  // also the OR over every slot mask; it doubles as the duplicate filter.
  always_comb begin
    w_stall     = '0;
    w_rel_mask  = '0;
    w_rel_valid = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if (w_state[b] != c_IDLE) begin
        w_stall = w_stall | w_mask[b];
      end
      if (w_state[b] == c_RELEASE) begin
        w_rel_valid = 1'b1;
        w_rel_mask  = w_rel_mask | w_mask[b];
      end
    end
  end

  assign w_ready  = (w_state[req_id] != c_RELEASE);
  assign w_dup    = |(w_stall & w_onehot);
  assign w_accept = req_valid && w_ready;
  // A duplicate is accepted but must not touch any slot.
  assign w_arrive = w_accept && !w_dup;

  generate
    for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_slot
      logic [1:0]           r_state;
      logic [NUM_WARPS-1:0] r_mask;
      logic [NW_BITS-1:0]   r_count;
      logic [NW_BITS-1:0]   w_new_count;
      logic                 w_hit;

      // The counter holds arrivals-minus-one, so the first arrival lands at 0
      // and completion is a direct compare against size_m1.
      assign w_new_count = (r_state == c_IDLE) ? '0 : r_count + NW_BITS'(1);
      assign w_hit       = w_arrive && (req_id == NB_BITS'(b));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state <= c_IDLE;
          r_mask  <= '0;
          r_count <= '0;
        end else if (r_state == c_RELEASE) begin
          r_state <= c_IDLE;
          r_mask  <= '0;
          r_count <= '0;
        end else if (w_hit) begin
          r_state <= (w_new_count == req_size_m1) ? c_RELEASE : c_COLLECT;
          r_mask  <= r_mask | w_onehot;
          r_count <= w_new_count;
        end
      end

      assign w_state[b] = r_state;
      assign w_mask[b]  = r_mask;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_dup <= 1'b0;
    end else begin
      r_err_dup <= w_accept && w_dup;
    end
  end

  assign req_ready     = w_ready;
  assign stall_mask    = w_stall;
  assign release_valid = w_rel_valid;
  assign release_wmask = w_rel_mask;
  assign err_dup       = r_err_dup;

endmodule
`default_nettype wire

// File: tb/tb_vx_barrier_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vx_barrier_unit                                           |
// | Description : Self-checking bench for vx_barrier_unit. Directed barrier    |
// |               scenarios followed by random traffic, all compared against   |
// |               a set-based reference model of the barrier slots.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vx_barrier_unit;

  localparam int NUM_WARPS    = 4;
  localparam int NUM_BARRIERS = 4;
  localparam int NW_BITS      = $clog2(NUM_WARPS);
  localparam int NB_BITS      = $clog2(NUM_BARRIERS);

  logic                 clk;
  logic                 reset_n;
  logic                 req_valid;
  logic [NW_BITS-1:0]   req_wid;
  logic [NB_BITS-1:0]   req_id;
  logic [NW_BITS-1:0]   req_size_m1;
  logic                 req_ready;
  logic [NUM_WARPS-1:0] stall_mask;
  logic                 release_valid;
  logic [NUM_WARPS-1:0] release_wmask;
  logic                 err_dup;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each slot is a set of member warps plus a flag saying
  // the set is being handed back this cycle.
  logic [NUM_WARPS-1:0] m_members [NUM_BARRIERS];
  bit                   m_rel     [NUM_BARRIERS];
  bit                   m_err;
  int                   rsz       [NUM_BARRIERS];

  vx_barrier_unit #(
    .NUM_WARPS    (NUM_WARPS),
    .NUM_BARRIERS (NUM_BARRIERS)
  ) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_wid       (req_wid),
    .req_id        (req_id),
    .req_size_m1   (req_size_m1),
    .req_ready     (req_ready),
    .stall_mask    (stall_mask),
    .release_valid (release_valid),
    .release_wmask (release_wmask),
    .err_dup       (err_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      m_members[b] = '0;
      m_rel[b]     = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic compare_outputs();
    logic [NUM_WARPS-1:0] e_stall;
    logic [NUM_WARPS-1:0] e_wmask;
    bit                   e_rv;
    e_stall = '0;
    e_wmask = '0;
    e_rv    = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      e_stall = e_stall | m_members[b];
      if (m_rel[b]) begin
        e_rv    = 1'b1;
        e_wmask = e_wmask | m_members[b];
      end
    end
    check("stall_mask", 32'(stall_mask), 32'(e_stall));
    check("release_valid", 32'(release_valid), 32'(e_rv));
    check("release_wmask", 32'(release_wmask), 32'(e_wmask));
    check("err_dup", 32'(err_dup), 32'(m_err));
    check("req_ready", 32'(req_ready), 32'(!m_rel[req_id]));
  endtask

  // Advance the model by one clock using the current request.
  task automatic model_step();
    logic [NUM_WARPS-1:0] n_members [NUM_BARRIERS];
    bit                   n_rel     [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] held;
    logic [NUM_WARPS-1:0] bitw;
    bit                   n_err;
    held  = '0;
    n_err = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      held         = held | m_members[b];
      n_members[b] = m_rel[b] ? '0 : m_members[b];
      n_rel[b]     = 1'b0;
    end
    bitw = '0;
    bitw[req_wid] = 1'b1;
    if (req_valid && !m_rel[req_id]) begin
      if ((held & bitw) != '0) begin
        n_err = 1'b1;
      end else begin
        n_members[req_id] = n_members[req_id] | bitw;
        if ($countones(n_members[req_id]) == int'(req_size_m1) + 1)
          n_rel[req_id] = 1'b1;
      end
    end
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      m_members[b] = n_members[b];
      m_rel[b]     = n_rel[b];
    end
    m_err = n_err;
  endtask

  // One cycle: apply request, check outputs mid-cycle, then clock the model.
  task automatic drive(input bit v, input int wid, input int id, input int sz);
    req_valid   = v;
    req_wid     = NW_BITS'(wid);
    req_id      = NB_BITS'(id);
    req_size_m1 = NW_BITS'(sz);
    @(negedge clk);
    compare_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0);
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_wid     = '0;
    req_id      = '0;
    req_size_m1 = '0;
    model_clear();
    #3;
    check("rst_stall", 32'(stall_mask), 32'h0);
    check("rst_release_valid", 32'(release_valid), 32'h0);
    check("rst_err_dup", 32'(err_dup), 32'h0);
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      req_id = NB_BITS'(i);
      #1;
      check("rst_ready", 32'(req_ready), 32'h1);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    // Four-warp barrier on id 1.
    drive(1'b1, 0, 1, 3);
    check("b4_stall_1", 32'(stall_mask), 32'h1);
    drive(1'b1, 1, 1, 3);
    check("b4_stall_2", 32'(stall_mask), 32'h3);
    drive(1'b1, 2, 1, 3);
    check("b4_stall_3", 32'(stall_mask), 32'h7);
    drive(1'b1, 3, 1, 3);
    check("b4_rel_valid", 32'(release_valid), 32'h1);
    check("b4_rel_wmask", 32'(release_wmask), 32'hF);
    idle(1);
    check("b4_stall_after", 32'(stall_mask), 32'h0);

    // Single-warp barrier: release next cycle, slot not ready meanwhile.
    drive(1'b1, 2, 0, 0);
    req_id = '0;
    #1;
    check("b1_rel_valid", 32'(release_valid), 32'h1);
    check("b1_rel_wmask", 32'(release_wmask), 32'h4);
    check("b1_ready_id0", 32'(req_ready), 32'h0);
    idle(1);

    // Duplicate arrival across slots.
    drive(1'b1, 1, 2, 1);
    drive(1'b1, 1, 3, 1);
    check("dup_pulse", 32'(err_dup), 32'h1);
    check("dup_stall", 32'(stall_mask), 32'h2);
    idle(1);
    check("dup_once", 32'(err_dup), 32'h0);
    drive(1'b1, 0, 3, 1);
    drive(1'b1, 2, 3, 1);
    check("dup_id3_fresh", 32'(release_wmask), 32'h5);
    drive(1'b1, 3, 2, 1);
    check("dup_id2_done", 32'(release_wmask), 32'hA);
    idle(1);

    // Barrier 0 releases while barrier 1 takes its first warp.
    drive(1'b1, 0, 0, 1);
    drive(1'b1, 1, 0, 1);
    drive(1'b1, 2, 1, 1);
    check("ilv_stall", 32'(stall_mask), 32'h4);
    drive(1'b1, 3, 1, 1);
    check("ilv_rel_wmask", 32'(release_wmask), 32'hC);
    idle(2);

    // Asynchronous reset mid-collection.
    drive(1'b1, 0, 2, 3);
    drive(1'b1, 1, 2, 3);
    req_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_stall", 32'(stall_mask), 32'h0);
    check("arst_release_valid", 32'(release_valid), 32'h0);
    check("arst_release_wmask", 32'(release_wmask), 32'h0);
    check("arst_err_dup", 32'(err_dup), 32'h0);
    check("arst_ready", 32'(req_ready), 32'h1);
    model_clear();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(4);

    // Random traffic with a consistent size per slot episode.
    for (int b = 0; b < NUM_BARRIERS; b++) rsz[b] = $urandom_range(0, 3);
    for (int cyc = 0; cyc < 400; cyc++) begin
      int id;
      id = $urandom_range(0, NUM_BARRIERS - 1);
      if (m_members[id] == '0 && !m_rel[id]) rsz[id] = $urandom_range(0, 3);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, NUM_WARPS - 1), id, rsz[id]);
      // Periodic reset prevents deadlock where every warp is held.
      if (cyc % 64 == 63) begin
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        check("rand_rst_stall", 32'(stall_mask), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
      end
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
